count_down_60s: RTL and testbench

- Settable 0–59 s countdown timer. It is the down-counting counterpart of the up-counting seconds display.
- The user loads a start value as two BCD digits, then starts, pauses and resumes the countdown. The timer flags expiry at 00.
- It drives a 2-digit seven-segment display through the existing bcd and seven_segment modules.
- It sits in the lab timer top level, clocked by the 1 Hz clock.

---
 rtl/timer_pkg.sv | 15 +
 rtl/bcd.sv | 28 ++
 rtl/bcd_to_bin.sv | 25 ++
 rtl/seven_segment.sv | 27 ++
 rtl/count_down_60s.sv | 119 +++++++++++
 tb/tb_count_down_60s.sv | 184 ++++++++++++++++++
 6 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and limits for the countdown timer
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t PAUSED = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int SECOND_MAX = 60;
  localparam int DIGIT_MAX  = 9;
  localparam int TENS_MAX   = 5;

endpackage

// File: rtl/bcd.sv
// rtl/bcd.sv - binary seconds to two BCD digits (combinational)
module bcd #(
  parameter int sec_num = 6,
  parameter int n       = 4
) (
  input  logic [sec_num-1:0] bin,
  output logic [n-1:0]       tens,
  output logic [n-1:0]       ones
);

  localparam int ITER = (2 ** sec_num) / 10;

  logic [sec_num-1:0] rem;

  // Repeated subtraction of ten; the loop is fully unrolled.
  always_comb begin
    rem  = bin;
    tens = '0;
    for (int i = 0; i < ITER; i++) begin
      if (rem >= sec_num'(10)) begin
        rem  = rem - sec_num'(10);
        tens = tens + n'(1);
      end
    end
    ones = n'(rem);
  end

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - two BCD digits to binary seconds, saturating out-of-range input
module bcd_to_bin
  import timer_pkg::*;
#(
  parameter int n          = 4,
  parameter int sec_num    = 6,
  parameter int second_max = SECOND_MAX
) (
  input  logic [n-1:0]       tens,
  input  logic [n-1:0]       ones,
  output logic [sec_num-1:0] value,
  output logic               err
);

  localparam int W = 2 * n;

  logic [W-1:0] sum;

  always_comb begin
    sum   = W'(tens) * W'(10) + W'(ones);
    err   = (tens > n'(TENS_MAX)) || (ones > n'(DIGIT_MAX));
    value = err ? sec_num'(second_max - 1) : sec_num'(sum);
  end

endmodule

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - BCD digit to active-high segments, bit order {g,f,e,d,c,b,a}
module seven_segment #(
  parameter int n           = 4,
  parameter int segment_num = 7
) (
  input  logic [n-1:0]           digit,
  output logic [segment_num-1:0] segment
);

  always_comb begin
    segment = '0;
    case (digit)
      4'd0: segment = 7'b0111111;
      4'd1: segment = 7'b0000110;
      4'd2: segment = 7'b1011011;
      4'd3: segment = 7'b1001111;
      4'd4: segment = 7'b1100110;
      4'd5: segment = 7'b1101101;
      4'd6: segment = 7'b1111101;
      4'd7: segment = 7'b0000111;
      4'd8: segment = 7'b1111111;
      4'd9: segment = 7'b1101111;
      default: segment = '0;
    endcase
  end

endmodule

// File: rtl/count_down_60s.sv
// rtl/count_down_60s.sv - settable 0-59 s countdown with 2-digit seven-segment display
// Optional: COUNT_DOWN_AUTO_RELOAD_EN restarts from the loaded value on expiry.
module count_down_60s
  import timer_pkg::*;
#(
  parameter int led_num     = 2,
  parameter int n           = 4,
  parameter int sec_num     = 6,
  parameter int second_max  = SECOND_MAX,
  parameter int segment_num = 7
) (
  input  logic                             clk_1Hz,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [n-1:0]                     load_tens,
  input  logic [n-1:0]                     load_ones,
  input  logic                             start,
  input  logic                             pause,
  output logic [led_num*segment_num-1:0]   second_led,
  output logic [sec_num-1:0]               seconds_out,
  output logic                             running,
  output logic                             done,
  output logic                             load_err
);

  state_t             state;
  logic [sec_num-1:0] seconds;
  logic [sec_num-1:0] reload_val;
  logic [sec_num-1:0] load_value;
  logic               load_bad;
  logic               resume;

  bcd_to_bin #(.n(n), .sec_num(sec_num), .second_max(second_max)) u_bcd_to_bin (
    .tens  (load_tens),
    .ones  (load_ones),
    .value (load_value),
    .err   (load_bad)
  );

  // pause outranks start, so both high never (re)enters RUN
  assign resume = start && !pause;

  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      state      <= IDLE;
      seconds    <= '0;
      reload_val <= '0;
      load_err   <= 1'b0;
    end else if (load) begin
      state      <= IDLE;
      seconds    <= load_value;
      reload_val <= load_value;
      load_err   <= load_bad;
    end else begin
      case (state)
        IDLE: begin
          if (resume) state <= (seconds == '0) ? DONE : RUN;
        end
        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else if (seconds == '0) begin
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
            if (reload_val == '0) state <= DONE;
            else seconds <= reload_val;
`else
            state <= DONE;
`endif
          end else begin
            seconds <= seconds - sec_num'(1);
`ifndef COUNT_DOWN_AUTO_RELOAD_EN
            if (seconds == sec_num'(1)) state <= DONE;
`endif
          end
        end
        PAUSED: begin
          if (resume) state <= RUN;
        end
        default: begin
          seconds <= '0;
        end
      endcase
    end
  end

  assign running     = (state == RUN);
  assign seconds_out = seconds;

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
  // Expiry is a one-cycle pulse while RUN sits at zero before reloading.
  assign done = (state == DONE) || ((state == RUN) && (seconds == '0));
`else
  assign done = (state == DONE);
`endif

  logic [n-1:0]           disp_tens;
  logic [n-1:0]           disp_ones;
  logic [segment_num-1:0] seg_tens;
  logic [segment_num-1:0] seg_ones;

  bcd #(.sec_num(sec_num), .n(n)) u_bcd (
    .bin  (seconds),
    .tens (disp_tens),
    .ones (disp_ones)
  );

  seven_segment #(.n(n), .segment_num(segment_num)) u_seg_tens (
    .digit   (disp_tens),
    .segment (seg_tens)
  );

  seven_segment #(.n(n), .segment_num(segment_num)) u_seg_ones (
    .digit   (disp_ones),
    .segment (seg_ones)
  );

  assign second_led = {seg_tens, seg_ones};

endmodule

// File: tb/tb_count_down_60s.sv
// tb/tb_count_down_60s.sv - scoreboard bench for count_down_60s
module tb_count_down_60s;

  logic        clk_1Hz = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  load_tens = '0;
  logic [3:0]  load_ones = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [13:0] second_led;
  logic [5:0]  seconds_out;
  logic        running;
  logic        done;
  logic        load_err;

  count_down_60s dut (
    .clk_1Hz     (clk_1Hz),
    .rst_n       (rst_n),
    .load        (load),
    .load_tens   (load_tens),
    .load_ones   (load_ones),
    .start       (start),
    .pause       (pause),
    .second_led  (second_led),
    .seconds_out (seconds_out),
    .running     (running),
    .done        (done),
    .load_err    (load_err)
  );

  always #5 clk_1Hz = ~clk_1Hz;

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;
  typedef struct {
    int          sec;
    bit          run;
    bit          dn;
    bit          err;
    logic [13:0] led;
  } exp_t;

  exp_t  q[$];
  mode_t m_mode = M_IDLE;
  int    m_sec = 0;
  int    m_reload = 0;
  bit    m_err = 1'b0;
  int    n_pass = 0;
  int    n_total = 0;
  bit    stim_done = 1'b0;

  task automatic model_step(bit r, bit ld, int t, int o, bit st, bit pa);
    if (!r) begin
      m_mode = M_IDLE; m_sec = 0; m_reload = 0; m_err = 1'b0;
    end else if (ld) begin
      m_err    = (t > 5) || (o > 9);
      m_sec    = m_err ? 59 : t * 10 + o;
      m_reload = m_sec;
      m_mode   = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:   if (st && !pa) m_mode = (m_sec == 0) ? M_DONE : M_RUN;
        M_PAUSED: if (st && !pa) m_mode = M_RUN;
        M_DONE:   m_sec = 0;
        M_RUN: begin
          if (pa) m_mode = M_PAUSED;
          else if (m_sec == 0) begin
            if (m_reload == 0) m_mode = M_DONE;
            else m_sec = m_reload;
          end else begin
            m_sec = m_sec - 1;
            if (m_sec == 0 && !AUTO) m_mode = M_DONE;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(bit r, bit ld, int t, int o, bit st, bit pa);
    exp_t e;
    @(negedge clk_1Hz);
    rst_n = r; load = ld; load_tens = 4'(t); load_ones = 4'(o);
    start = st; pause = pa;
    model_step(r, ld, t, o, st, pa);
    e.sec = m_sec;
    e.run = (m_mode == M_RUN);
    e.dn  = (m_mode == M_DONE) || (AUTO && m_mode == M_RUN && m_sec == 0);
    e.err = m_err;
    e.led = {SEG[m_sec / 10], SEG[m_sec % 10]};
    q.push_back(e);
  endtask

  task automatic check(string name, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every edge presents a new output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_1Hz);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("seconds_out", int'(seconds_out), e.sec);
        check("running", int'(running), int'(e.run));
        check("done", int'(done), int'(e.dn));
        check("load_err", int'(load_err), int'(e.err));
        check("second_led", int'(second_led), int'(e.led));
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 2, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 44; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 7, 3, 0, 0);
    cyc(1, 1, 0, 5, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 3, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit r, ld, st, pa;
      int t, o;
      r  = ($urandom_range(99) >= 2);
      ld = ($urandom_range(99) < 6);
      st = ($urandom_range(99) < 30);
      pa = ($urandom_range(99) < 10);
      t  = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : int'($urandom_range(5));
      o  = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : int'($urandom_range(9));
      if (ld && $urandom_range(3) == 0) begin t = 0; o = int'($urandom_range(4)); end
      cyc(r, ld, t, o, st, pa);
    end
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 20000) begin
      @(posedge clk_1Hz);
      budget++;
    end
    repeat (2) @(posedge clk_1Hz);
    #2;
    check("stimulus_finished", int'(stim_done), 1);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
